// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX pipeline register bus: decoded ID fields in, registered EX fields and stall out
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            valid_ID;
  logic [XLEN-1:0] pc_ID;
  logic [XLEN-1:0] rs1_data_ID;
  logic [XLEN-1:0] rs2_data_ID;
  logic [XLEN-1:0] imm_ID;
  logic [4:0]      rs1_ID;
  logic [4:0]      rs2_ID;
  logic [4:0]      rd_ID;
  logic            uses_rs1_ID;
  logic            uses_rs2_ID;
  logic            RegWrite_ID;
  logic            MemRead_ID;
  logic            MemWrite_ID;
  logic            MemtoReg_ID;
  logic            ALUSrc_ID;
  logic [3:0]      ALUOp_ID;
  logic            flush_EX;

  logic [XLEN-1:0] pc_EX;
  logic [XLEN-1:0] rs1_data_EX;
  logic [XLEN-1:0] rs2_data_EX;
  logic [XLEN-1:0] imm_EX;
  logic [4:0]      rs1_EX;
  logic [4:0]      rs2_EX;
  logic [4:0]      rd_EX;
  logic            RegWrite_EX;
  logic            MemRead_EX;
  logic            MemWrite_EX;
  logic            MemtoReg_EX;
  logic            ALUSrc_EX;
  logic            valid_EX;
  logic [3:0]      ALUOp_EX;
  logic            stall_ID;

  modport slave (
    input  valid_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID,
    input  rs1_ID, rs2_ID, rd_ID, uses_rs1_ID, uses_rs2_ID,
    input  RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, ALUOp_ID,
    input  flush_EX,
    output pc_EX, rs1_data_EX, rs2_data_EX, imm_EX, rs1_EX, rs2_EX, rd_EX,
    output RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, valid_EX, ALUOp_EX,
    output stall_ID
  );

  modport master (
    output valid_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID,
    output rs1_ID, rs2_ID, rd_ID, uses_rs1_ID, uses_rs2_ID,
    output RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, ALUOp_ID,
    output flush_EX,
    input  pc_EX, rs1_data_EX, rs2_data_EX, imm_EX, rs1_EX, rs2_EX, rd_EX,
    input  RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, valid_EX, ALUOp_EX,
    input  stall_ID
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and flush bubbles
// Optional bubble counter output bubble_cnt enabled by macro ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [15:0]  bubble_cnt
`endif
);

  localparam logic [XLEN-1:0] ZERO_W = '0;

  logic load_use;
  logic rs1_hit;
  logic rs2_hit;
  logic squash;

  assign rs1_hit  = bus.uses_rs1_ID & (bus.rs1_ID == bus.rd_EX);
  assign rs2_hit  = bus.uses_rs2_ID & (bus.rs2_ID == bus.rd_EX);
  assign load_use = bus.valid_EX & bus.MemRead_EX & (bus.rd_EX != 5'd0) &
                    bus.valid_ID & (rs1_hit | rs2_hit);

  // A coinciding flush kills the ID instruction upstream, so holding it would be pointless.
  assign bus.stall_ID = load_use & ~bus.flush_EX;
  assign squash       = bus.flush_EX | load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_EX    <= 1'b0;
      bus.pc_EX       <= ZERO_W;
      bus.rs1_data_EX <= ZERO_W;
      bus.rs2_data_EX <= ZERO_W;
      bus.imm_EX      <= ZERO_W;
      bus.rs1_EX      <= 5'd0;
      bus.rs2_EX      <= 5'd0;
      bus.rd_EX       <= 5'd0;
      bus.RegWrite_EX <= 1'b0;
      bus.MemRead_EX  <= 1'b0;
      bus.MemWrite_EX <= 1'b0;
      bus.MemtoReg_EX <= 1'b0;
      bus.ALUSrc_EX   <= 1'b0;
      bus.ALUOp_EX    <= 4'd0;
    end else if (squash) begin
      bus.valid_EX    <= 1'b0;
      bus.pc_EX       <= ZERO_W;
      bus.rs1_data_EX <= ZERO_W;
      bus.rs2_data_EX <= ZERO_W;
      bus.imm_EX      <= ZERO_W;
      bus.rs1_EX      <= 5'd0;
      bus.rs2_EX      <= 5'd0;
      bus.rd_EX       <= 5'd0;
      bus.RegWrite_EX <= 1'b0;
      bus.MemRead_EX  <= 1'b0;
      bus.MemWrite_EX <= 1'b0;
      bus.MemtoReg_EX <= 1'b0;
      bus.ALUSrc_EX   <= 1'b0;
      bus.ALUOp_EX    <= 4'd0;
    end else begin
      bus.valid_EX    <= bus.valid_ID;
      bus.pc_EX       <= bus.pc_ID;
      bus.rs1_data_EX <= bus.rs1_data_ID;
      bus.rs2_data_EX <= bus.rs2_data_ID;
      bus.imm_EX      <= bus.imm_ID;
      bus.rs1_EX      <= bus.rs1_ID;
      bus.rs2_EX      <= bus.rs2_ID;
      bus.rd_EX       <= bus.rd_ID;
      // State-changing controls are gated so an invalid slot can never write or load.
      bus.RegWrite_EX <= bus.RegWrite_ID & bus.valid_ID;
      bus.MemRead_EX  <= bus.MemRead_ID & bus.valid_ID;
      bus.MemWrite_EX <= bus.MemWrite_ID & bus.valid_ID;
      bus.MemtoReg_EX <= bus.MemtoReg_ID;
      bus.ALUSrc_EX   <= bus.ALUSrc_ID;
      bus.ALUOp_EX    <= bus.ALUOp_ID;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= 16'd0;
    end else if (load_use && !bus.flush_EX && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - table-driven check of id_ex_stage hazard, flush, reset and counter behaviour
module tb_id_ex_stage;

  logic clk;
  logic rst;

  id_ex_stage_if #(.XLEN(32)) bus ();

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] bubble_cnt;
  id_ex_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus), .bubble_cnt(bubble_cnt));
`else
  id_ex_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v, rs1, rs2, rd, u1, u2, rw, mr, mw, mtr, als, aluop, pc, r1d, imm, flush;
    int stall;
    int e_v, e_rd, e_rs1, e_rw, e_mr, e_mw, e_aluop, e_pc, e_imm, e_r1d, e_bub;
  } vec_t;

  localparam int NV = 18;
  vec_t vt[NV];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bubble(input string tag);
    chk({tag, " valid_EX"},    32'(bus.valid_EX),    32'd0);
    chk({tag, " pc_EX"},       bus.pc_EX,            32'd0);
    chk({tag, " rs1_data_EX"}, bus.rs1_data_EX,      32'd0);
    chk({tag, " rs2_data_EX"}, bus.rs2_data_EX,      32'd0);
    chk({tag, " imm_EX"},      bus.imm_EX,           32'd0);
    chk({tag, " rs1_EX"},      32'(bus.rs1_EX),      32'd0);
    chk({tag, " rs2_EX"},      32'(bus.rs2_EX),      32'd0);
    chk({tag, " rd_EX"},       32'(bus.rd_EX),       32'd0);
    chk({tag, " RegWrite_EX"}, 32'(bus.RegWrite_EX), 32'd0);
    chk({tag, " MemRead_EX"},  32'(bus.MemRead_EX),  32'd0);
    chk({tag, " MemWrite_EX"}, 32'(bus.MemWrite_EX), 32'd0);
    chk({tag, " MemtoReg_EX"}, 32'(bus.MemtoReg_EX), 32'd0);
    chk({tag, " ALUSrc_EX"},   32'(bus.ALUSrc_EX),   32'd0);
    chk({tag, " ALUOp_EX"},    32'(bus.ALUOp_EX),    32'd0);
  endtask

  task automatic drive(input vec_t v);
    bus.valid_ID    = v.v[0];
    bus.rs1_ID      = v.rs1[4:0];
    bus.rs2_ID      = v.rs2[4:0];
    bus.rd_ID       = v.rd[4:0];
    bus.uses_rs1_ID = v.u1[0];
    bus.uses_rs2_ID = v.u2[0];
    bus.RegWrite_ID = v.rw[0];
    bus.MemRead_ID  = v.mr[0];
    bus.MemWrite_ID = v.mw[0];
    bus.MemtoReg_ID = v.mtr[0];
    bus.ALUSrc_ID   = v.als[0];
    bus.ALUOp_ID    = v.aluop[3:0];
    bus.pc_ID       = v.pc;
    bus.rs1_data_ID = v.r1d;
    bus.rs2_data_ID = v.r1d ^ 32'h0F0F_0000;
    bus.imm_ID      = v.imm;
    bus.flush_EX    = v.flush[0];
  endtask

  task automatic id_instr(input int valid, input int rs1, input int rd, input int mr, input int pc);
    vec_t t;
    t = '{valid, rs1, 0, rd, 1, 0, 1, mr, 0, mr, mr, 0, pc, 32'h1234, 0, 0,
          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(t);
  endtask

  initial begin
    // v, rs1,rs2,rd, u1,u2, rw,mr,mw,mtr,als, aluop, pc, r1d, imm, flush | stall | e_v,e_rd,e_rs1,e_rw,e_mr,e_mw,e_aluop,e_pc,e_imm,e_r1d,e_bub
    vt[0]  = '{1,1,2,3,    1,0, 1,0,0,0,0, 2, 32'h100, 32'h11,   32'h5, 0, 0, 1,3,1,  1,0,0, 2, 32'h100, 32'h5,  32'h11,   0};
    vt[1]  = '{1,2,0,5,    1,0, 1,1,0,1,1, 0, 32'h104, 32'h1000, 32'h8, 0, 0, 1,5,2,  1,1,0, 0, 32'h104, 32'h8,  32'h1000, 0};
    vt[2]  = '{1,5,1,6,    1,1, 1,0,0,0,0, 1, 32'h108, 32'hAA,   32'h0, 0, 1, 0,0,0,  0,0,0, 0, 32'h0,   32'h0,  32'h0,    1};
    vt[3]  = '{1,5,1,6,    1,1, 1,0,0,0,0, 1, 32'h108, 32'hAA,   32'h0, 0, 0, 1,6,5,  1,0,0, 1, 32'h108, 32'h0,  32'hAA,   0};
    vt[4]  = '{1,1,0,0,    1,0, 1,1,0,1,1, 0, 32'h10C, 32'h20,   32'h4, 0, 0, 1,0,1,  1,1,0, 0, 32'h10C, 32'h4,  32'h20,   0};
    vt[5]  = '{1,0,0,8,    1,0, 1,0,0,0,0, 0, 32'h110, 32'h30,   32'h0, 0, 0, 1,8,0,  1,0,0, 0, 32'h110, 32'h0,  32'h30,   0};
    vt[6]  = '{1,1,0,7,    1,0, 1,1,0,1,1, 0, 32'h114, 32'h40,   32'h0, 0, 0, 1,7,1,  1,1,0, 0, 32'h114, 32'h0,  32'h40,   0};
    vt[7]  = '{1,3,7,9,    1,0, 1,0,0,0,1, 6, 32'h118, 32'h50,   32'h1F,0, 0, 1,9,3,  1,0,0, 6, 32'h118, 32'h1F, 32'h50,   0};
    vt[8]  = '{1,1,0,4,    1,0, 1,1,0,1,1, 0, 32'h11C, 32'h60,   32'h0, 0, 0, 1,4,1,  1,1,0, 0, 32'h11C, 32'h0,  32'h60,   0};
    vt[9]  = '{1,0,4,10,   0,1, 1,0,0,0,0, 0, 32'h120, 32'h70,   32'h0, 1, 0, 0,0,0,  0,0,0, 0, 32'h0,   32'h0,  32'h0,    1};
    vt[10] = '{0,4,0,11,   1,0, 1,1,1,0,0, 3, 32'h124, 32'h55,   32'h7, 0, 0, 0,11,4, 0,0,0, 3, 32'h124, 32'h7,  32'h55,   0};
    vt[11] = '{1,2,11,0,   1,1, 0,0,1,0,1, 0, 32'h128, 32'h99,   32'hC, 0, 0, 1,0,2,  0,0,1, 0, 32'h128, 32'hC,  32'h99,   0};
    vt[12] = '{1,1,0,12,   1,0, 1,1,0,1,1, 0, 32'h12C, 32'h80,   32'h0, 0, 0, 1,12,1, 1,1,0, 0, 32'h12C, 32'h0,  32'h80,   0};
    vt[13] = '{0,12,0,13,  1,0, 1,0,0,0,0, 0, 32'h130, 32'h90,   32'h0, 0, 0, 0,13,12,0,0,0, 0, 32'h130, 32'h0,  32'h90,   0};
    vt[14] = '{1,1,0,14,   1,0, 1,1,0,1,1, 0, 32'h134, 32'hA0,   32'h0, 0, 0, 1,14,1, 1,1,0, 0, 32'h134, 32'h0,  32'hA0,   0};
    vt[15] = '{1,0,14,15,  1,1, 1,0,0,0,0, 5, 32'h138, 32'h77,   32'h0, 0, 1, 0,0,0,  0,0,0, 0, 32'h0,   32'h0,  32'h0,    1};
    vt[16] = '{1,0,14,15,  1,1, 1,0,0,0,0, 5, 32'h138, 32'h77,   32'h0, 0, 0, 1,15,0, 1,0,0, 5, 32'h138, 32'h0,  32'h77,   0};
    vt[17] = '{1,2,3,16,   1,1, 1,0,0,0,0, 2, 32'h13C, 32'hB0,   32'h0, 1, 0, 0,0,0,  0,0,0, 0, 32'h0,   32'h0,  32'h0,    1};

    rst = 1'b1;
    id_instr(0, 0, 0, 0, 0);
    #2;
    check_bubble("reset_async");
    chk("reset stall_ID", 32'(bus.stall_ID), 32'd0);
    @(posedge clk); #1;
    check_bubble("reset_hold");
    #2 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i]);
      #2;
      chk($sformatf("v%0d stall_ID", i), 32'(bus.stall_ID), vt[i].stall);
      @(posedge clk); #1;
      chk($sformatf("v%0d valid_EX", i),    32'(bus.valid_EX),    vt[i].e_v);
      chk($sformatf("v%0d rd_EX", i),       32'(bus.rd_EX),       vt[i].e_rd);
      chk($sformatf("v%0d rs1_EX", i),      32'(bus.rs1_EX),      vt[i].e_rs1);
      chk($sformatf("v%0d RegWrite_EX", i), 32'(bus.RegWrite_EX), vt[i].e_rw);
      chk($sformatf("v%0d MemRead_EX", i),  32'(bus.MemRead_EX),  vt[i].e_mr);
      chk($sformatf("v%0d MemWrite_EX", i), 32'(bus.MemWrite_EX), vt[i].e_mw);
      chk($sformatf("v%0d ALUOp_EX", i),    32'(bus.ALUOp_EX),    vt[i].e_aluop);
      chk($sformatf("v%0d pc_EX", i),       bus.pc_EX,            vt[i].e_pc);
      chk($sformatf("v%0d imm_EX", i),      bus.imm_EX,           vt[i].e_imm);
      chk($sformatf("v%0d rs1_data_EX", i), bus.rs1_data_EX,      vt[i].e_r1d);
      if (vt[i].e_bub != 0) check_bubble($sformatf("v%0d bubble", i));
    end

    // Asynchronous reset between edges while EX holds lw x10 and ID depends on it.
    id_instr(1, 1, 10, 1, 32'h200);
    @(posedge clk); #1;
    chk("pre_rst rd_EX", 32'(bus.rd_EX), 32'd10);
    id_instr(1, 10, 17, 0, 32'h204);
    #1;
    chk("pre_rst stall_ID", 32'(bus.stall_ID), 32'd1);
    rst = 1'b1;
    #1;
    check_bubble("mid_rst");
    chk("mid_rst stall_ID", 32'(bus.stall_ID), 32'd0);
    @(posedge clk); #1;
    check_bubble("rst_held");
    #2 rst = 1'b0;
    #1;
    chk("post_rst stall_ID", 32'(bus.stall_ID), 32'd0);
    @(posedge clk); #1;
    chk("post_rst valid_EX", 32'(bus.valid_EX), 32'd1);
    chk("post_rst rd_EX",    32'(bus.rd_EX),    32'd17);
    chk("post_rst pc_EX",    bus.pc_EX,         32'h204);

`ifdef ID_EX_PERF_CNT_EN
    chk("cnt after reset", 32'(bubble_cnt), 32'd0);
    // lw x5 reading x5, held in ID: every second edge is a load-use bubble.
    id_instr(1, 5, 5, 1, 32'h300);
    repeat (6) @(posedge clk);
    #1;
    chk("cnt three stalls", 32'(bubble_cnt), 32'd3);
    chk("cnt three valid_EX", 32'(bus.valid_EX), 32'd0);
    @(posedge clk); #1;
    chk("cnt lw loaded", 32'(bus.MemRead_EX), 32'd1);
    bus.flush_EX = 1'b1;
    #1;
    chk("flush+hazard stall_ID", 32'(bus.stall_ID), 32'd0);
    @(posedge clk); #1;
    chk("flush+hazard cnt", 32'(bubble_cnt), 32'd3);
    chk("flush+hazard valid_EX", 32'(bus.valid_EX), 32'd0);
    bus.flush_EX = 1'b0;
    repeat (2 * 65535) @(posedge clk);
    #1;
    chk("cnt saturated", 32'(bubble_cnt), 32'h0000FFFF);
    repeat (4) @(posedge clk);
    #1;
    chk("cnt stays saturated", 32'(bubble_cnt), 32'h0000FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port valid_ID  input  1  ID holds a real instruction.
REQ-005 SHALL have ports pc_ID, rs1_data_ID, rs2_data_ID, imm_ID  input  XLEN  decoded operands.
REQ-006 SHALL have ports rs1_ID, rs2_ID, rd_ID  input  5  register indices.
REQ-007 SHALL have ports uses_rs1_ID, uses_rs2_ID  input  1  instruction actually reads rs1/rs2.
REQ-008 SHALL have ports RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID  input  1  control bits.
REQ-009 SHALL have port ALUOp_ID  input  4  ALU operation.
REQ-010 SHALL have port flush_EX  input  1  taken branch/jump resolved in EX; squash ID/EX.
REQ-011 SHALL have outputs pc_EX, rs1_data_EX, rs2_data_EX, imm_EX (XLEN), rs1_EX, rs2_EX, rd_EX (5), RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, valid_EX (1), ALUOp_EX (4); registered copies for EX and Forwarding_Unit.
REQ-012 SHALL have port stall_ID  output  1  hold PC and IF/ID this cycle.

Function
REQ-013 SHALL compute load_use = valid_EX & MemRead_EX & (rd_EX != 0) & valid_ID & ((uses_rs1_ID & rs1_ID == rd_EX) | (uses_rs2_ID & rs2_ID == rd_EX)), combinational from registered EX state and ID inputs.
REQ-014 SHALL drive stall_ID = load_use & ~flush_EX; combinational, same cycle.
REQ-015 SHALL, on a rising edge with flush_EX=1, load a bubble regardless of load_use (flush has priority).
REQ-016 SHALL, on a rising edge with flush_EX=0 and load_use=1, load a bubble.
REQ-017 SHALL, otherwise, load all ID fields into EX fields with 1-cycle latency and valid_EX=valid_ID.
REQ-018 SHALL, when valid_ID=0 is loaded, force RegWrite_EX, MemRead_EX, MemWrite_EX to 0.
REQ-019 SHALL define a bubble as valid_EX=0, all control bits 0, ALUOp_EX=0, rs1_EX=rs2_EX=rd_EX=0, data/pc/imm fields 0.
REQ-020 SHALL insert exactly one bubble per load-use hazard; next cycle valid_EX=0 so load_use deasserts and the held instruction advances.
REQ-021 SHALL never stall on rd_EX=x0 or on unused source fields.
REQ-022 SHALL not stall when load_use and flush_EX coincide; the ID instruction is squashed upstream.

Reset
REQ-023 SHALL on rst=1 asynchronously set every registered output to the bubble values of REQ-019 and the counter of REQ-026 to 0.
REQ-024 SHALL hold bubble values while rst=1; stall_ID SHALL be 0 during reset because valid_EX=0.
REQ-025 SHALL, on reset deassertion mid-stream, resume loading on the first subsequent rising edge.

Configuration
REQ-026 SHALL, with macro ID_EX_PERF_CNT_EN defined, add output bubble_cnt (16 bits) counting edges where load_use=1 and flush_EX=0, saturating at 16'hFFFF.
REQ-027 SHALL, without ID_EX_PERF_CNT_EN, omit the bubble_cnt port and counter entirely; all other behaviour identical.

Verification
REQ-028 SHALL cover: valid_ID=1, rs1_ID=1, rd_ID=3, RegWrite_ID=1, no hazard -> next edge rd_EX=3, RegWrite_EX=1, valid_EX=1, stall_ID=0.
REQ-029 SHALL cover: EX holds lw x5 (MemRead_EX=1, rd_EX=5), ID add with rs1_ID=5, uses_rs1_ID=1 -> stall_ID=1; next edge valid_EX=0, rd_EX=0; following edge add loaded, stall_ID=0.
REQ-030 SHALL cover: EX holds lw x0, ID rs1_ID=0 -> stall_ID=0; also lw x7 with ID rs2_ID=7, uses_rs2_ID=0 -> stall_ID=0.
REQ-031 SHALL cover: load-use condition plus flush_EX=1 -> stall_ID=0, next edge bubble, bubble_cnt unchanged.
REQ-032 SHALL cover: rst pulsed between edges while valid_EX=1, rd_EX=10 -> outputs go to bubble values immediately, before any clock edge.
REQ-033 SHALL cover (ID_EX_PERF_CNT_EN): three separate load-use stalls -> bubble_cnt=3; counter preloaded near limit by forcing 65535 stalls -> stays 16'hFFFF.
